// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller bus: decode/execute/memory status in, stall/flush controls and counters out.
// The pipeline side (master) drives status; the controller (slave) drives controls.
interface pipeline_hazard_ctrl_if #(
  parameter int RW   = 4,
  parameter int CNTW = 16
);
  logic [RW-1:0]   id_ra;
  logic            id_ra_isreg;
  logic [RW-1:0]   id_rb;
  logic            id_rb_isreg;
  logic [RW-1:0]   ex_rd;
  logic            ex_wb;
  logic            ex_memrd;
  logic            ex_branch_taken;
  logic            mem_req;
  logic            mem_ready;
  logic            pc_stall;
  logic            fd_stall;
  logic            fd_flush;
  logic            de_stall;
  logic            de_flush;
  logic            em_stall;
  logic            mw_bubble;
  logic            busy;
  logic            err_timeout;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] flush_cnt;
  logic [CNTW-1:0] ldu_cnt;

  modport master (
    output id_ra, id_ra_isreg, id_rb, id_rb_isreg, ex_rd, ex_wb, ex_memrd,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, mw_bubble,
           busy, err_timeout, stall_cnt, flush_cnt, ldu_cnt
  );

  modport slave (
    input  id_ra, id_ra_isreg, id_rb, id_rb_isreg, ex_rd, ex_wb, ex_memrd,
           ex_branch_taken, mem_req, mem_ready,
    output pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, mw_bubble,
           busy, err_timeout, stall_cnt, flush_cnt, ldu_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: load-use bubbles, taken-branch flushes,
// memory-wait freeze with timeout, and saturating performance counters.
module pipeline_hazard_ctrl #(
  parameter int RW          = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNTW        = 16
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int WW = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_ERROR} state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic            err_q, err_d;
  logic [CNTW-1:0] stall_cnt_q, flush_cnt_q, ldu_cnt_q;

  logic ldu, frz, normal, ldu_stall;

  always_comb begin
    ldu = bus.ex_memrd & bus.ex_wb &
          ((bus.id_ra_isreg & (bus.id_ra == bus.ex_rd)) |
           (bus.id_rb_isreg & (bus.id_rb == bus.ex_rd)));
    frz     = 1'b0;
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    case (state_q)
      S_RUN: begin
        if (bus.mem_req & ~bus.mem_ready) begin
          frz     = 1'b1;
          state_d = S_MEM_WAIT;
          wcnt_d  = WW'(1);
        end
      end
      S_MEM_WAIT: begin
        // Only mem_ready releases the freeze; a dropped mem_req is ignored.
        if (bus.mem_ready) begin
          state_d = S_RUN;
          wcnt_d  = '0;
        end else begin
          frz = 1'b1;
          if (wcnt_q == WW'(MEM_TIMEOUT - 1)) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end
      end
      S_ERROR: frz = 1'b1;
      default: state_d = S_RUN;
    endcase
  end

  assign normal    = ~rst & ~frz;
  assign ldu_stall = normal & ~bus.ex_branch_taken & ldu;

  assign bus.pc_stall    = (~rst & frz) | ldu_stall;
  assign bus.fd_stall    = (~rst & frz) | ldu_stall;
  assign bus.fd_flush    = normal & bus.ex_branch_taken;
  assign bus.de_flush    = normal & (bus.ex_branch_taken | ldu);
  assign bus.de_stall    = ~rst & frz;
  assign bus.em_stall    = ~rst & frz;
  assign bus.mw_bubble   = ~rst & frz;
  assign bus.busy        = ~rst & (state_q != S_RUN);
  assign bus.err_timeout = err_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
  assign bus.ldu_cnt     = ldu_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      wcnt_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      ldu_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      if (bus.pc_stall && (stall_cnt_q != {CNTW{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNTW'(1);
      if (bus.fd_flush && (flush_cnt_q != {CNTW{1'b1}}))
        flush_cnt_q <= flush_cnt_q + CNTW'(1);
      if (ldu_stall && (ldu_cnt_q != {CNTW{1'b1}}))
        ldu_cnt_q <= ldu_cnt_q + CNTW'(1);
    end
  end

endmodule
